pipe_fifo: RTL and testbench



---
 rtl/pipe_fifo.sv | 148 ++++++++++++++
 tb/tb_pipe_fifo.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_fifo.sv
// pipe_fifo: DEPTH-entry AXI-Stream FIFO with a registered output word, tlast sideband,
// fill level and almost-full status. Define PIPE_FIFO_FLUSH_EN to add the synchronous flush port.
module pipe_fifo #(
    parameter int BITS        = 32,
    parameter int DEPTH       = 4,
    parameter int ALMOST_FULL = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
`ifdef PIPE_FIFO_FLUSH_EN
    input  logic                       flush,
`endif
    input  logic                       recv_tvalid,
    output logic                       recv_tready,
    input  logic [BITS-1:0]            recv_tdata,
    input  logic                       recv_tlast,
    output logic                       send_tvalid,
    input  logic                       send_tready,
    output logic [BITS-1:0]            send_tdata,
    output logic                       send_tlast,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       almost_full
);

    localparam int RAM_D = DEPTH - 1;
    localparam int PW    = (RAM_D > 1) ? $clog2(RAM_D) : 1;
    localparam int CW    = $clog2(DEPTH);
    localparam int LW    = $clog2(DEPTH+1);

    // Handshake: a word moves only on a rising edge where tvalid and tready are both high;
    // a source never waits on tready to raise tvalid, and holds its word until accepted.

    logic [BITS:0]     ram_q [RAM_D];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [BITS-1:0]   out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic [LW-1:0]     level_q, level_d;
    logic              ready_q, ready_d;
    logic              af_q, af_d;

    logic push, pop, out_take, ram_rd, ram_wr, ram_we;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RAM_D-1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        push     = recv_tvalid && ready_q;
        pop      = out_valid_q && send_tready;
        // The output slot refills from the RAM first, so an empty slot implies an empty RAM.
        out_take = !out_valid_q || pop;
        ram_rd   = out_take && (cnt_q != '0);
        ram_wr   = push && !(out_take && (cnt_q == '0));
        ram_we   = ram_wr;

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        level_d     = level_q;

        if (out_take) begin
            if (ram_rd) begin
                out_valid_d              = 1'b1;
                {out_last_d, out_data_d} = ram_q[rd_ptr_q];
            end else if (push) begin
                out_valid_d = 1'b1;
                out_data_d  = recv_tdata;
                out_last_d  = recv_tlast;
            end else begin
                out_valid_d = 1'b0;
            end
        end

        if (ram_wr) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (ram_rd) rd_ptr_d = ptr_inc(rd_ptr_q);

        case ({ram_wr, ram_rd})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

`ifdef PIPE_FIFO_FLUSH_EN
        if (flush) begin
            ram_we      = 1'b0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_last_d  = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            cnt_d       = '0;
            level_d     = '0;
        end
`endif

        // Status is registered from the post-edge level, so it never looks ahead.
        ready_d = (level_d != LW'(DEPTH));
        af_d    = (level_d >= LW'(ALMOST_FULL));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            level_q     <= '0;
            ready_q     <= 1'b0;
            af_q        <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            ready_q     <= ready_d;
            af_q        <= af_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && ram_we) ram_q[wr_ptr_q] <= {recv_tlast, recv_tdata};
    end

    assign recv_tready = ready_q;
    assign send_tvalid = out_valid_q;
    assign send_tdata  = out_data_q;
    assign send_tlast  = out_last_q;
    assign level       = level_q;
    assign almost_full = af_q;

endmodule

// File: tb/tb_pipe_fifo.sv
// Bench for pipe_fifo: three instances (DEPTH 4, 3, 5) share one stimulus stream and are
// checked every cycle against an ideal-queue model, plus table vectors and corner sequences.
module tb_pipe_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_v = 1'b0;
    logic        in_l = 1'b0;
    logic        out_r = 1'b0;
    logic [31:0] in_d = '0;

    logic        rr_a, sv_a, sl_a, af_a;
    logic [31:0] sd_a;
    logic [2:0]  lv_a;
    logic        rr_b, sv_b, sl_b, af_b;
    logic [31:0] sd_b;
    logic [1:0]  lv_b;
    logic        rr_c, sv_c, sl_c, af_c;
    logic [31:0] sd_c;
    logic [2:0]  lv_c;

    logic        o_rr [3];
    logic        o_sv [3];
    logic        o_sl [3];
    logic        o_af [3];
    logic [31:0] o_sd [3];
    logic [2:0]  o_lv [3];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    pipe_fifo #(.BITS(32), .DEPTH(4)) u_d4 (
        .clk(clk), .rst_n(rst_n),
`ifdef PIPE_FIFO_FLUSH_EN
        .flush(flush),
`endif
        .recv_tvalid(in_v), .recv_tready(rr_a), .recv_tdata(in_d), .recv_tlast(in_l),
        .send_tvalid(sv_a), .send_tready(out_r), .send_tdata(sd_a), .send_tlast(sl_a),
        .level(lv_a), .almost_full(af_a)
    );

    pipe_fifo #(.BITS(32), .DEPTH(3), .ALMOST_FULL(2)) u_d3 (
        .clk(clk), .rst_n(rst_n),
`ifdef PIPE_FIFO_FLUSH_EN
        .flush(flush),
`endif
        .recv_tvalid(in_v), .recv_tready(rr_b), .recv_tdata(in_d), .recv_tlast(in_l),
        .send_tvalid(sv_b), .send_tready(out_r), .send_tdata(sd_b), .send_tlast(sl_b),
        .level(lv_b), .almost_full(af_b)
    );

    pipe_fifo #(.BITS(32), .DEPTH(5)) u_d5 (
        .clk(clk), .rst_n(rst_n),
`ifdef PIPE_FIFO_FLUSH_EN
        .flush(flush),
`endif
        .recv_tvalid(in_v), .recv_tready(rr_c), .recv_tdata(in_d), .recv_tlast(in_l),
        .send_tvalid(sv_c), .send_tready(out_r), .send_tdata(sd_c), .send_tlast(sl_c),
        .level(lv_c), .almost_full(af_c)
    );

    assign o_rr[0] = rr_a;  assign o_sv[0] = sv_a;  assign o_sl[0] = sl_a;
    assign o_af[0] = af_a;  assign o_sd[0] = sd_a;  assign o_lv[0] = lv_a;
    assign o_rr[1] = rr_b;  assign o_sv[1] = sv_b;  assign o_sl[1] = sl_b;
    assign o_af[1] = af_b;  assign o_sd[1] = sd_b;  assign o_lv[1] = {1'b0, lv_b};
    assign o_rr[2] = rr_c;  assign o_sv[2] = sv_c;  assign o_sl[2] = sl_c;
    assign o_af[2] = af_c;  assign o_sd[2] = sd_c;  assign o_lv[2] = lv_c;

    // Reference: each instance behaves as an ideal queue of capacity DEPTH.
    int          m_depth [3] = '{4, 3, 5};
    int          m_af    [3] = '{3, 2, 4};
    logic [32:0] m_mem   [3][8];
    int          m_head  [3] = '{0, 0, 0};
    int          m_cnt   [3] = '{0, 0, 0};
    int          m_push  [3] = '{0, 0, 0};
    logic        m_rdy   [3] = '{1'b0, 1'b0, 1'b0};
    logic        m_zero  [3] = '{1'b1, 1'b1, 1'b1};

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        r;
        logic        e_sv;
        logic [31:0] e_sd;
        logic [2:0]  e_lv;
        logic        e_rr;
        logic        e_af;
    } vec_t;

    vec_t tab [16];

    task automatic chk(input string nm, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", nm, inst, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            bit push, pop;
            push = in_v && m_rdy[i];
            pop  = out_r && (m_cnt[i] > 0);
            if (!rst_n) begin
                m_cnt[i] = 0; m_head[i] = 0; m_rdy[i] = 1'b0; m_zero[i] = 1'b1;
            end else if (flush) begin
                m_cnt[i] = 0; m_head[i] = 0; m_rdy[i] = 1'b1; m_zero[i] = 1'b1;
            end else begin
                if (pop) begin
                    m_head[i] = (m_head[i] + 1) % 8;
                    m_cnt[i]--;
                end
                if (push) begin
                    m_mem[i][(m_head[i] + m_cnt[i]) % 8] = {in_l, in_d};
                    m_cnt[i]++;
                    m_push[i]++;
                    m_zero[i] = 1'b0;
                end
                m_rdy[i] = (m_cnt[i] != m_depth[i]);
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            logic [32:0] head;
            head = m_mem[i][m_head[i]];
            chk("recv_tready", i, 32'(o_rr[i]), 32'(m_rdy[i]));
            chk("send_tvalid", i, 32'(o_sv[i]), 32'(m_cnt[i] > 0));
            chk("level", i, 32'(o_lv[i]), 32'(m_cnt[i]));
            chk("almost_full", i, 32'(o_af[i]), 32'(m_cnt[i] >= m_af[i]));
            if (m_cnt[i] > 0) begin
                chk("send_tdata", i, o_sd[i], head[31:0]);
                chk("send_tlast", i, 32'(o_sl[i]), 32'(head[32]));
            end else if (m_zero[i]) begin
                chk("send_tdata_zero", i, o_sd[i], 32'h0);
                chk("send_tlast_zero", i, 32'(o_sl[i]), 32'h0);
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_v = 1'b0; out_r = 1'b0; flush = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic run_tab(input int inst, input int n);
        for (int i = 0; i < n; i++) begin
            in_v = tab[i].v; in_d = tab[i].d; in_l = 1'b0; out_r = tab[i].r;
            step();
            chk("tab_tvalid", inst, 32'(o_sv[inst]), 32'(tab[i].e_sv));
            chk("tab_level", inst, 32'(o_lv[inst]), 32'(tab[i].e_lv));
            chk("tab_tready", inst, 32'(o_rr[inst]), 32'(tab[i].e_rr));
            chk("tab_afull", inst, 32'(o_af[inst]), 32'(tab[i].e_af));
            if (tab[i].e_sv) chk("tab_tdata", inst, o_sd[inst], tab[i].e_sd);
        end
    endtask

    initial begin
        // Reset held three cycles with a word offered.
        rst_n = 1'b0; in_v = 1'b1; in_d = 32'h11; out_r = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                chk("rst_tready", i, 32'(o_rr[i]), 32'h0);
                chk("rst_tvalid", i, 32'(o_sv[i]), 32'h0);
                chk("rst_level", i, 32'(o_lv[i]), 32'h0);
            end
        end
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("release_tready", i, 32'(o_rr[i]), 32'h1);
            chk("release_level", i, 32'(o_lv[i]), 32'h0);
        end
        in_v = 1'b0;

        // Streaming through DEPTH=4 with the sink always ready.
        for (int i = 0; i < 16; i++)
            tab[i] = '{v: 1'b1, d: 32'(i + 1), r: 1'b1, e_sv: 1'b1, e_sd: 32'(i + 1),
                       e_lv: 3'd1, e_rr: 1'b1, e_af: 1'b0};
        run_tab(0, 16);
        in_v = 1'b0; out_r = 1'b1;
        step();
        chk("stream_drained", 0, 32'(o_sv[0]), 32'h0);

        // Fill and drain DEPTH=3 against a stalled sink.
        do_reset();
        tab[0] = '{1'b1, 32'd1, 1'b0, 1'b1, 32'd1, 3'd1, 1'b1, 1'b0};
        tab[1] = '{1'b1, 32'd2, 1'b0, 1'b1, 32'd1, 3'd2, 1'b1, 1'b1};
        tab[2] = '{1'b1, 32'd3, 1'b0, 1'b1, 32'd1, 3'd3, 1'b0, 1'b1};
        tab[3] = '{1'b1, 32'd4, 1'b0, 1'b1, 32'd1, 3'd3, 1'b0, 1'b1};
        tab[4] = '{1'b1, 32'd5, 1'b0, 1'b1, 32'd1, 3'd3, 1'b0, 1'b1};
        tab[5] = '{1'b0, 32'd0, 1'b1, 1'b1, 32'd2, 3'd2, 1'b1, 1'b1};
        tab[6] = '{1'b0, 32'd0, 1'b1, 1'b1, 32'd3, 3'd1, 1'b1, 1'b0};
        tab[7] = '{1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 3'd0, 1'b1, 1'b0};
        run_tab(1, 8);

        // Reset mid-operation while a pop and a push are both in flight.
        do_reset();
        in_v = 1'b1; in_d = 32'hA1; out_r = 1'b0;
        step();
        in_d = 32'hA2;
        step();
        chk("pre_reset_level", 0, 32'(o_lv[0]), 32'h2);
        in_d = 32'hA3; out_r = 1'b1; rst_n = 1'b0;
        step();
        chk("midrst_tvalid", 0, 32'(o_sv[0]), 32'h0);
        chk("midrst_tdata", 0, o_sd[0], 32'h0);
        chk("midrst_tlast", 0, 32'(o_sl[0]), 32'h0);
        chk("midrst_level", 0, 32'(o_lv[0]), 32'h0);
        chk("midrst_afull", 0, 32'(o_af[0]), 32'h0);
        chk("midrst_tready", 0, 32'(o_rr[0]), 32'h0);
        rst_n = 1'b1; in_v = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("midrst_no_old_word", 0, 32'(o_sv[0]), 32'h0);
        end

`ifdef PIPE_FIFO_FLUSH_EN
        // Flush at full with a concurrent push of 0xAA.
        do_reset();
        out_r = 1'b0; in_v = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_d = 32'(k + 1);
            step();
        end
        chk("prefl_level", 0, 32'(o_lv[0]), 32'h4);
        flush = 1'b1; in_d = 32'hAA;
        step();
        flush = 1'b0;
        chk("flush_level", 0, 32'(o_lv[0]), 32'h0);
        chk("flush_tvalid", 0, 32'(o_sv[0]), 32'h0);
        chk("flush_tdata", 0, o_sd[0], 32'h0);
        chk("flush_tready", 0, 32'(o_rr[0]), 32'h1);
        in_d = 32'h55;
        step();
        in_v = 1'b0;
        chk("postfl_tvalid", 0, 32'(o_sv[0]), 32'h1);
        chk("postfl_tdata", 0, o_sd[0], 32'h55);
        out_r = 1'b1;
        step();
        chk("postfl_empty", 0, 32'(o_sv[0]), 32'h0);
`endif

        // Random valid/ready, tlast on every 7th word accepted by the DEPTH=5 instance.
        do_reset();
        for (int k = 0; k < 8000 && m_push[2] < 1000; k++) begin
            in_v  = 1'($urandom_range(0, 1));
            out_r = 1'($urandom_range(0, 1));
            in_d  = $urandom;
            in_l  = ((m_push[2] + 1) % 7 == 0);
            step();
        end
        chk("random_word_budget", 2, 32'(m_push[2] >= 1000), 32'h1);
        in_v = 1'b0; out_r = 1'b1; in_l = 1'b0;
        for (int k = 0; k < 6; k++) step();
        for (int i = 0; i < 3; i++) chk("final_empty", i, 32'(o_lv[i]), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
